// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver for the joystick link: synchronises Rx, rejects start-bit glitches,
// samples each bit mid-period and checks the stop bit before presenting a byte.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk50,
    input  logic       nreset,
    input  logic       Rx,
    output logic [7:0] data,
    output logic       ready,
    output logic       ferr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_HALF    = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_BIT_END = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          rx_m_q, rx_s_q, rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          ferr_q, ferr_d;

    // Input synchroniser and edge-detect history; reset to idle-high so reset never looks like a start.
    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) begin
            rx_m_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_m_q    <= Rx;
            rx_s_q    <= rx_m_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Receiver state, counters and registered outputs.
    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            data_q    <= 8'h00;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state and datapath logic; cnt returns to zero on every state change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_ONE;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        ready_d   = ready_q;
        ferr_d    = ferr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = CNT_ZERO;
                    // ready only drops once the start bit is confirmed, so glitches leave it alone
                    if (!rx_s_q) begin
                        ready_d   = 1'b0;
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = CNT_ZERO;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = CNT_ZERO;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        data_d  = shreg_q;
                        ready_d = 1'b1;
                        ferr_d  = 1'b0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign data  = data_q;
    assign ready = ready_q;
    assign ferr  = ferr_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: drives 8N1 frames on Rx and checks the received
// byte stream, ready/ferr behaviour and timing against a frame-level expectation.
module tb_uart_rx_sampler;
    logic       clk50 = 1'b0;
    logic       nreset;
    logic       Rx;
    logic [7:0] data;
    logic       ready;
    logic       ferr;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int start_cyc = 0;

    logic [7:0] obs_q[$];
    int   rise_cnt      = 0;
    int   last_rise_cyc = 0;
    int   last_fall_cyc = 0;
    int   ferr_hits     = 0;
    logic ready_prev_m  = 1'b0;

    uart_rx_sampler dut (
        .clk50  (clk50),
        .nreset (nreset),
        .Rx     (Rx),
        .data   (data),
        .ready  (ready),
        .ferr   (ferr)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) cyc <= cyc + 1;

    // Observe outputs half a cycle after the active edge: record every byte delivered on a ready rise.
    always @(negedge clk50) begin
        if (ready === 1'b1 && ready_prev_m === 1'b0) begin
            obs_q.push_back(data);
            rise_cnt      = rise_cnt + 1;
            last_rise_cyc = cyc;
        end
        if (ready === 1'b0 && ready_prev_m === 1'b1) last_fall_cyc = cyc;
        if (ferr === 1'b1) ferr_hits = ferr_hits + 1;
        ready_prev_m = ready;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk50);
    endtask

    // Called on a negedge; returns on a negedge once the whole stop bit has been driven.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int period);
        Rx = 1'b0;
        start_cyc = cyc;
        repeat (period) @(negedge clk50);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (period) @(negedge clk50);
        end
        Rx = stop_bit;
        repeat (period) @(negedge clk50);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        Rx     = 1'b1;
        wait_cycles(5);
        total_cnt++;
        if ({data, ready, ferr} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset_in: data/ready/ferr=%h/%b/%b want 00/0/0", data, ready, ferr);
        else pass_cnt++;
        nreset = 1'b1;
        wait_cycles(20);
        total_cnt++;
        if ({data, ready, ferr} !== {8'h00, 1'b0, 1'b0} || rise_cnt !== 0)
            $display("FAIL reset_out: data/ready/ferr=%h/%b/%b rises=%0d want 00/0/0 rises=0",
                     data, ready, ferr, rise_cnt);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int r0;
        int s;
        int delta;
        r0 = rise_cnt;
        send_frame(8'hAA, 1'b1, 434);
        s = start_cyc;
        wait_cycles(20);
        delta = last_rise_cyc - s;
        total_cnt++;
        if (rise_cnt - r0 !== 1) $display("FAIL single_rises: got %0d want 1", rise_cnt - r0);
        else pass_cnt++;
        total_cnt++;
        if (data !== 8'hAA || ready !== 1'b1)
            $display("FAIL single_data: data=%h ready=%b want aa/1", data, ready);
        else pass_cnt++;
        // Rx fall -> 3 cycles to START entry -> 4123 to the stop sample
        total_cnt++;
        if (delta < 4125 || delta > 4127)
            $display("FAIL single_latency: got %0d cycles want 4126+-1", delta);
        else pass_cnt++;
        total_cnt++;
        if (ferr !== 1'b0) $display("FAIL single_ferr: got %b want 0", ferr);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int r0;
        int base;
        int s2;
        int delta;
        logic [7:0] got;
        r0   = rise_cnt;
        base = obs_q.size();
        send_frame(8'h55, 1'b1, 434);
        send_frame(8'h0F, 1'b1, 434);
        s2 = start_cyc;
        wait_cycles(20);
        total_cnt++;
        if (rise_cnt - r0 !== 2) $display("FAIL b2b_rises: got %0d want 2", rise_cnt - r0);
        else pass_cnt++;
        got = (obs_q.size() > base) ? obs_q[base] : 8'hxx;
        total_cnt++;
        if (got !== 8'h55) $display("FAIL b2b_byte0: got %h want 55", got);
        else pass_cnt++;
        got = (obs_q.size() > base + 1) ? obs_q[base+1] : 8'hxx;
        total_cnt++;
        if (got !== 8'h0F) $display("FAIL b2b_byte1: got %h want 0f", got);
        else pass_cnt++;
        delta = last_fall_cyc - s2;
        total_cnt++;
        if (delta < 219 || delta > 221)
            $display("FAIL b2b_ready_fall: got %0d cycles after edge want 220+-1", delta);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int r0;
        r0 = rise_cnt;
        Rx = 1'b0;
        wait_cycles(100);
        Rx = 1'b1;
        wait_cycles(600);
        total_cnt++;
        if ({data, ready, ferr} !== {8'h0F, 1'b1, 1'b0} || rise_cnt !== r0)
            $display("FAIL glitch_hold: data/ready/ferr=%h/%b/%b new_rises=%0d want 0f/1/0 0",
                     data, ready, ferr, rise_cnt - r0);
        else pass_cnt++;
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b1, 434);
        wait_cycles(10);
        total_cnt++;
        if (data !== 8'h3C || ready !== 1'b1 || ferr !== 1'b0)
            $display("FAIL frm_good: data/ready/ferr=%h/%b/%b want 3c/1/0", data, ready, ferr);
        else pass_cnt++;
        send_frame(8'hC3, 1'b0, 434);
        Rx = 1'b1;
        wait_cycles(10);
        total_cnt++;
        if (ferr !== 1'b1) $display("FAIL frm_err_flag: got %b want 1", ferr);
        else pass_cnt++;
        total_cnt++;
        if (ready !== 1'b0 || data !== 8'h3C)
            $display("FAIL frm_err_out: ready/data=%b/%h want 0/3c", ready, data);
        else pass_cnt++;
        wait_cycles(50);
        send_frame(8'h01, 1'b1, 434);
        wait_cycles(10);
        total_cnt++;
        if (ferr !== 1'b0) $display("FAIL frm_recover_ferr: got %b want 0", ferr);
        else pass_cnt++;
        total_cnt++;
        if (ready !== 1'b1 || data !== 8'h01)
            $display("FAIL frm_recover_out: ready/data=%b/%h want 1/01", ready, data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int base;
        logic [7:0] got;
        Rx = 1'b0;
        wait_cycles(434);
        Rx = 1'b1;
        wait_cycles(4 * 434 + 200);
        nreset = 1'b0;
        #1;
        total_cnt++;
        if ({data, ready, ferr} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL midrst_async: data/ready/ferr=%h/%b/%b want 00/0/0", data, ready, ferr);
        else pass_cnt++;
        wait_cycles(5);
        nreset = 1'b1;
        wait_cycles(2500);
        base = obs_q.size();
        send_frame(8'h7E, 1'b1, 434);
        wait_cycles(10);
        total_cnt++;
        if (data !== 8'h7E || ready !== 1'b1)
            $display("FAIL midrst_resume: data/ready=%h/%b want 7e/1", data, ready);
        else pass_cnt++;
        got = (obs_q.size() == base + 1) ? obs_q[base] : 8'hxx;
        total_cnt++;
        if (got !== 8'h7E) $display("FAIL midrst_stream: got %h (new=%0d) want single 7e",
                                    got, obs_q.size() - base);
        else pass_cnt++;
    endtask

    task automatic test_joystick_frame();
        logic [7:0] msg [7];
        logic [7:0] got;
        int base;
        int f0;
        msg = '{8'hAA, 8'hAA, 8'h34, 8'h02, 8'hFF, 8'h07, 8'h01};
        base = obs_q.size();
        f0   = ferr_hits;
        for (int i = 0; i < 7; i++) send_frame(msg[i], 1'b1, 434);
        wait_cycles(20);
        total_cnt++;
        if (obs_q.size() - base !== 7) $display("FAIL joy_count: got %0d want 7", obs_q.size() - base);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            got = (obs_q.size() > base + i) ? obs_q[base+i] : 8'hxx;
            total_cnt++;
            if (got !== msg[i]) $display("FAIL joy_byte%0d: got %h want %h", i, got, msg[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (ferr_hits !== f0) $display("FAIL joy_ferr: ferr high %0d cycles want 0", ferr_hits - f0);
        else pass_cnt++;
    endtask

    // Random bytes, idle gaps and a baud error of up to about +-1.8%.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [7:0] got;
        int base;
        int f0;
        int period;
        base = obs_q.size();
        f0   = ferr_hits;
        for (int i = 0; i < 3; i++) begin
            b      = 8'($urandom_range(0, 255));
            period = int'($urandom_range(426, 442));
            exp_q.push_back(b);
            send_frame(b, 1'b1, period);
            wait_cycles(int'($urandom_range(0, 40)));
        end
        wait_cycles(20);
        total_cnt++;
        if (obs_q.size() - base !== 3) $display("FAIL rnd_count: got %0d want 3", obs_q.size() - base);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            got = (obs_q.size() > base + i) ? obs_q[base+i] : 8'hxx;
            total_cnt++;
            if (got !== exp_q[i]) $display("FAIL rnd_byte%0d: got %h want %h", i, got, exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (ferr_hits !== f0) $display("FAIL rnd_ferr: ferr high %0d cycles want 0", ferr_hits - f0);
        else pass_cnt++;
    endtask

    initial begin
        nreset = 1'b0;
        Rx     = 1'b1;
        @(negedge clk50);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_joystick_frame();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Asynchronous serial receiver that converts the joystick's 8N1 UART line into parallel bytes for the joystick frame parser. It sits directly upstream of the parser: the parser consumes `data` on each rising edge of `ready`. It provides input synchronisation, start-bit glitch rejection, mid-bit sampling and stop-bit framing checks.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clk50 cycles per bit (50 MHz / 115200 baud). Must be at least 16.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (217): cycles from the start-bit edge to the start-bit mid-sample.

Ports:
- `clk50`, input, 1: system clock, 50 MHz, rising edge.
- `nreset`, input, 1: asynchronous, active-low reset.
- `Rx`, input, 1: serial line, asynchronous to clk50, idle high, LSB first, 8 data bits, no parity, 1 stop bit.
- `data`, output, 8: last correctly framed byte.
- `ready`, output, 1: high while `data` holds a new valid byte. Low for the duration of any frame in progress.
- `ferr`, output, 1: framing error flag for the most recent frame.

## Operation
- **Synchroniser.** Two-flop chain `Rx -> rx_m -> rx_s`, plus a `rx_prev` flop for edge detection. All three reset to 1 (idle line) so no false start can occur after reset.
- **Bit-period counter.** `cnt`, width `$clog2(CLKS_PER_BIT)`. Cleared on every state entry.
- **Bit index.** `bit_idx`, 3 bits.
- **Shift register.** `shreg`, 8 bits. Each sampled bit is shifted in at the MSB and the register shifts right, so bit 0 ends up at `data[0]`.

State machine:
- **IDLE:** when `rx_prev==1 && rx_s==0` (falling edge), go to START with `cnt=0`. A line that stays low, e.g. a break, never retriggers.
- **START:**
  - When `cnt==HALF_BIT-1`, sample `rx_s`.
  - If the sample is 0, the start bit is valid: clear `ready`, set `bit_idx=0`, go to DATA.
  - If the sample is 1, it was a glitch: go to IDLE with no output change.
- **DATA:**
  - When `cnt==CLKS_PER_BIT-1`, shift `rx_s` into `shreg` and clear `cnt`.
  - If `bit_idx==7`, go to STOP; otherwise increment `bit_idx`.
- **STOP:** when `cnt==CLKS_PER_BIT-1`, sample `rx_s`, then go to IDLE.
  - Sample is 1: `data<=shreg`, `ready<=1`, `ferr<=0`.
  - Sample is 0: `ferr<=1`. `data` is unchanged and `ready` stays 0.
- `ferr` is cleared on the next valid stop bit only. It is not cleared when a new start is accepted.
- `ready` stays high indefinitely across idle line time. It falls only when the next start bit is validated. This guarantees exactly one rising edge per good byte, including back-to-back frames.

## Timing
- **Reset values.** `data=8'h00`, `ready=0`, `ferr=0`, state IDLE, `cnt=0`, `bit_idx=0`, `shreg=0`, synchroniser flops = 1.
- **Reset mid-frame.** Reset takes effect immediately and asynchronously, abandoning the frame. The remainder of that frame may be misinterpreted only if its low bits form a falling edge. After reset, reception resumes on the next falling edge.
- **Input latency.** `Rx` to `rx_s` is 2 cycles. The falling edge is detected 1 cycle later, on the entry to START.
- **Sample points, relative to START entry:**
  - Start-bit check at cycle `HALF_BIT`.
  - Data bit k at cycle `HALF_BIT + (k+1)*CLKS_PER_BIT`.
  - Stop bit at cycle `HALF_BIT + 9*CLKS_PER_BIT`.
  - `ready`, `data` and `ferr` update on that same edge.
- **Defaults.** Stop sample at 217 + 3906 = 4123 cycles after START entry. Total `Rx` edge to `ready` is about 4126 cycles.
- **Back-to-back frames.** After the stop sample, IDLE accepts a falling edge on the very next cycle. The half stop bit remaining gives more than 200 cycles of margin at default timing.
- **Baud tolerance.** The receiver tolerates ±2% baud mismatch, since it samples mid-bit.
- **Data hold.** `data` is stable from the rise of `ready` until at least the next stop sample, so a consumer that samples on the `ready` rising edge, or on the cycle after it, always sees a consistent byte.

## Test plan
- **Single byte.** Drive 0xAA at 115200 baud (434 cycles/bit). Expect `data=8'hAA`, one `ready` rise 4123±1 cycles after START entry, and `ferr=0`.
- **Back-to-back.** Drive 0x55 then 0x0F with no idle gap.
  - `ready` falls 217 cycles after the second start edge.
  - `ready` then rises again with `data=8'h0F`.
  - Exactly two rising edges in total.
- **Glitch rejection.** Pulse `Rx` low for 100 cycles, then hold it high. Expect the state to return to IDLE, and `data`, `ready` and `ferr` unchanged.
- **Framing error.**
  - After a good 0x3C, send 0xC3 with its stop bit driven low. Expect `ferr=1`, `ready=0` and `data` still `8'h3C`.
  - Then send a good 0x01. Expect `ferr=0`, `ready=1` and `data=8'h01`.
- **Reset mid-frame.**
  - Assert `nreset` during data bit 4 of 0xFF. Expect all outputs at their reset values within the same cycle.
  - After release, send 0x7E. Expect `data=8'h7E` and `ready=1`.
- **Joystick frame.** Send 0xAA, 0xAA, 0x34, 0x02, 0xFF, 0x07, 0x01 back-to-back. Expect seven `ready` rising edges carrying those bytes in order, with `ferr=0` throughout.
